// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Contents: RV32I load/store funct3 encodings, the FSM state type and a
// helper that classifies a request as erroneous (illegal funct3 or, when
// alignment checking is enabled, a misaligned half/word access).
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;   // LB / SB
    localparam logic [2:0] F3_H  = 3'd1;   // LH / SH
    localparam logic [2:0] F3_W  = 3'd2;   // LW / SW
    localparam logic [2:0] F3_BU = 3'd4;   // LBU
    localparam logic [2:0] F3_HU = 3'd5;   // LHU

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP
    } lsu_state_t;

    // Error if funct3 is not a legal load/store encoding, or if the access
    // is a misaligned half/word and alignment checking is switched on.
    function automatic logic access_error(
        input logic       store,
        input logic [2:0] funct3,
        input logic [1:0] addr_lo,
        input logic       check_align
    );
        logic bad_f3;
        logic misaligned;
        if (store) begin
            bad_f3 = (funct3 > F3_W);
        end else begin
            bad_f3 = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end
        misaligned = check_align &&
                     (((funct3[1:0] == 2'd1) && addr_lo[0]) ||
                      ((funct3[1:0] == 2'd2) && (addr_lo != 2'b00)));
        return bad_f3 || misaligned;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational data alignment for the load/store unit.
// Ports:
//   funct3     in  3   captured funct3 of the access
//   addr_lo    in  2   captured address bits [1:0]
//   word       in  32  memory word read at the aligned address
//   wdata      in  32  right-aligned store data
//   load_data  out 32  extracted and sign/zero-extended load value
//   merge_word out 32  memory word with the addressed store lanes replaced
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  lane_hit;

    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        // Only addr[1] selects the half lane, so with alignment checks off
        // a half access at an odd address behaves as if aligned.
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        load_data = word;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = word;
        endcase
    end

    // Store merge: each byte lane takes store data when addressed, else
    // keeps the current memory contents.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_src;
            assign lane_hit[gi] = (funct3[1:0] == 2'd0) ? (addr_lo == 2'(gi)) :
                                  (funct3[1:0] == 2'd1) ? (addr_lo[1] == 1'(gi / 2)) :
                                  1'b1;
            assign lane_src = (funct3[1:0] == 2'd0) ? wdata[7:0] :
                              (funct3[1:0] == 2'd1) ? wdata[8*(gi%2) +: 8] :
                              wdata[8*gi +: 8];
            assign merge_word[8*gi +: 8] = lane_hit[gi] ? lane_src : word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one access at a time from the CPU,
// performs it against a word-wide data memory with combinational read,
// and returns a single-cycle response pulse.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_valid/ready    request handshake (ready only while idle)
//   req_store          1 = store, 0 = load
//   req_funct3         RV32I funct3 of the access
//   req_addr/wdata     byte address, right-aligned store data
//   resp_valid         one-cycle completion pulse
//   resp_rdata/err     load result (0 for stores/errors), error flag
//   mem_we/addr/wdata  data memory write port (word-aligned address)
//   mem_rdata          data memory read word at mem_addr
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state_reg;
    logic [2:0]  funct3_reg;
    logic        store_reg;
    logic [1:0]  addr_lo_reg;
    logic [31:0] wdata_reg;
    logic        resp_valid_reg;
    logic [31:0] resp_rdata_reg;
    logic        resp_err_reg;
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;

    logic [31:0] load_data;
    logic [31:0] merge_word;

    lsu_align u_align (
        .funct3     (funct3_reg),
        .addr_lo    (addr_lo_reg),
        .word       (mem_rdata),
        .wdata      (wdata_reg),
        .load_data  (load_data),
        .merge_word (merge_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            funct3_reg     <= 3'd0;
            store_reg      <= 1'b0;
            addr_lo_reg    <= 2'd0;
            wdata_reg      <= 32'd0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 32'd0;
            resp_err_reg   <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= 32'd0;
            mem_wdata_reg  <= 32'd0;
        end else begin
            // Pulses by default; set only on the transition into WR/RESP.
            mem_we_reg     <= 1'b0;
            resp_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        funct3_reg   <= req_funct3;
                        store_reg    <= req_store;
                        addr_lo_reg  <= req_addr[1:0];
                        wdata_reg    <= req_wdata;
                        mem_addr_reg <= {req_addr[31:2], 2'b00};
                        if (access_error(req_store, req_funct3, req_addr[1:0], CHECK_ALIGN)) begin
                            state_reg      <= ST_RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= 1'b1;
                            resp_rdata_reg <= 32'd0;
                        end else if (req_store && (req_funct3 == F3_W)) begin
                            // Full-word store needs no read-modify-write.
                            state_reg     <= ST_WR;
                            mem_we_reg    <= 1'b1;
                            mem_wdata_reg <= req_wdata;
                        end else begin
                            state_reg <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (store_reg) begin
                        state_reg     <= ST_WR;
                        mem_we_reg    <= 1'b1;
                        mem_wdata_reg <= merge_word;
                    end else begin
                        state_reg      <= ST_RESP;
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= 1'b0;
                        resp_rdata_reg <= load_data;
                    end
                end
                ST_WR: begin
                    state_reg      <= ST_RESP;
                    resp_valid_reg <= 1'b1;
                    resp_err_reg   <= 1'b0;
                    resp_rdata_reg <= 32'd0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_reg == ST_IDLE);
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-level reference memory
// model, directed literal cases, reset abort, and randomized traffic.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Second instance with alignment checking disabled.
    logic        na_req_ready;
    logic        na_resp_valid;
    logic [31:0] na_resp_rdata;
    logic        na_resp_err;
    logic        na_mem_we;
    logic [31:0] na_mem_addr;
    logic [31:0] na_mem_wdata;
    logic [31:0] na_mem_rdata;

    logic [31:0] mem    [0:255];
    logic [31:0] na_mem [0:255];
    logic [7:0]  ref_mem [0:1023];

    int checks = 0;
    int errors = 0;
    int txn_no = 0;
    int na_cnt = 0;
    logic [31:0] na_rdata_seen = 32'd0;
    logic        na_err_seen   = 1'b1;

    load_store_unit #(.CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.CHECK_ALIGN(1'b0)) dut_na (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(na_req_ready),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(na_resp_valid), .resp_rdata(na_resp_rdata),
        .resp_err(na_resp_err), .mem_we(na_mem_we), .mem_addr(na_mem_addr),
        .mem_wdata(na_mem_wdata), .mem_rdata(na_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata    = mem[mem_addr[9:2]];
    assign na_mem_rdata = na_mem[na_mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_we)    mem[mem_addr[9:2]]       <= mem_wdata;
        if (na_mem_we) na_mem[na_mem_addr[9:2]] <= na_mem_wdata;
        if (na_resp_valid && !rst) begin
            na_cnt        <= na_cnt + 1;
            na_rdata_seen <= na_resp_rdata;
            na_err_seen   <= na_resp_err;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int base);
        return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    endfunction

    // Runs one access; entered and left at a falling edge with the DUT idle.
    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] got_rdata,
                           output logic [31:0] got_wword, output int got_lat,
                           output logic got_err);
        logic        bad_f3;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_wword;
        int          exp_lat;
        int          exp_wr;
        int          nbytes;
        int          ea;
        int          wbase;
        int          wr_cnt;
        bit          done;

        // Reference model: size from funct3, byte-addressed memory.
        bad_f3  = st ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        nbytes  = 1 << f3[1:0];
        if (nbytes > 4) nbytes = 4;
        exp_err = bad_f3 || ((int'(addr) % nbytes) != 0);
        ea      = int'(addr) - (int'(addr) % nbytes);
        wbase   = int'(addr) - (int'(addr) % 4);
        exp_rdata = 32'd0;
        exp_wword = 32'd0;
        exp_wr    = 0;
        if (exp_err) begin
            exp_lat = 1;
        end else if (!st) begin
            exp_lat = 2;
            for (int k = 0; k < nbytes; k++) exp_rdata |= 32'(ref_mem[ea+k]) << (8*k);
            if (f3 < 3'd4 && nbytes < 4 && exp_rdata >= (32'd1 << (8*nbytes - 1)))
                exp_rdata = exp_rdata - (32'd1 << (8*nbytes));
        end else begin
            exp_lat = (nbytes == 4) ? 2 : 3;
            for (int k = 0; k < nbytes; k++) ref_mem[ea+k] = wd[8*k +: 8];
            exp_wword = ref_word(wbase);
            exp_wr    = 1;
        end

        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);

        got_rdata = 32'd0;
        got_wword = 32'd0;
        got_lat   = 0;
        got_err   = 1'b0;
        wr_cnt    = 0;
        done      = 1'b0;
        for (int n = 1; n <= 8 && !done; n++) begin
            check("mem_addr_hold", mem_addr, 32'(wbase));
            if (mem_we) begin
                wr_cnt++;
                got_wword = mem_wdata;
                check("mem_wdata", mem_wdata, exp_wword);
            end
            if (resp_valid) begin
                done      = 1'b1;
                got_lat   = n;
                got_rdata = resp_rdata;
                got_err   = resp_err;
                req_valid = 1'b0;
            end else begin
                // Busy: requests must be ignored, so throw junk at the inputs.
                req_valid  = 1'($urandom_range(0, 1));
                req_store  = 1'($urandom);
                req_funct3 = 3'($urandom);
                req_addr   = $urandom;
                req_wdata  = $urandom;
                @(negedge clk);
            end
        end
        if (!done) begin
            check("resp_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(got_lat), 32'(exp_lat));
            check("resp_err", 32'(got_err), 32'(exp_err));
            check("resp_rdata", got_rdata, exp_rdata);
        end
        check("write_count", 32'(wr_cnt), 32'(exp_wr));
        @(negedge clk);
        check("resp_pulse_end", 32'(resp_valid), 32'd0);
        check("ready_after", 32'(req_ready), 32'd1);
        check("rdata_hold", resp_rdata, exp_rdata);
        check("err_hold", 32'(resp_err), 32'(exp_err));
        $display("TXN %0d st=%0d f3=%0d addr=%h wdata=%h lat=%0d err=%0d rdata=%h wword=%h",
                 txn_no, st, f3, addr, wd, got_lat, got_err, got_rdata, got_wword);
        txn_no++;
    endtask

    logic [31:0] r_rdata;
    logic [31:0] r_wword;
    int          r_lat;
    logic        r_err;

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] w;
            w = (i == 64) ? 32'h8899AABB : $urandom;
            mem[i]    = w;
            na_mem[i] = w;
            for (int k = 0; k < 4; k++) ref_mem[4*i+k] = w[8*k +: 8];
        end

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Misaligned LW: error here, plain load on the unchecked instance.
        run_txn(1'b0, 3'd2, 32'h102, 32'd0, r_rdata, r_wword, r_lat, r_err);
        check("lw102_lat", 32'(r_lat), 32'd1);
        check("lw102_err", 32'(r_err), 32'd1);
        check("lw102_rdata", r_rdata, 32'd0);
        repeat (2) @(negedge clk);
        check("na_resp_count", 32'(na_cnt), 32'd1);
        check("na_lw102_rdata", na_rdata_seen, 32'h8899AABB);
        check("na_lw102_err", 32'(na_err_seen), 32'd0);

        run_txn(1'b0, 3'd2, 32'h100, $urandom, r_rdata, r_wword, r_lat, r_err);
        check("lw_lit", r_rdata, 32'h8899AABB);
        check("lw_lat", 32'(r_lat), 32'd2);
        run_txn(1'b0, 3'd0, 32'h103, $urandom, r_rdata, r_wword, r_lat, r_err);
        check("lb_lit", r_rdata, 32'hFFFFFF88);
        run_txn(1'b0, 3'd4, 32'h103, $urandom, r_rdata, r_wword, r_lat, r_err);
        check("lbu_lit", r_rdata, 32'h00000088);
        run_txn(1'b0, 3'd1, 32'h102, $urandom, r_rdata, r_wword, r_lat, r_err);
        check("lh_lit", r_rdata, 32'hFFFF8899);
        run_txn(1'b0, 3'd5, 32'h100, $urandom, r_rdata, r_wword, r_lat, r_err);
        check("lhu_lit", r_rdata, 32'h0000AABB);
        run_txn(1'b1, 3'd0, 32'h101, 32'h12345677, r_rdata, r_wword, r_lat, r_err);
        check("sb_lit", r_wword, 32'h889977BB);
        check("sb_lat", 32'(r_lat), 32'd3);
        run_txn(1'b1, 3'd2, 32'h100, 32'h8899AABB, r_rdata, r_wword, r_lat, r_err);
        run_txn(1'b1, 3'd1, 32'h102, 32'h0000CAFE, r_rdata, r_wword, r_lat, r_err);
        check("sh_lit", r_wword, 32'hCAFEAABB);
        run_txn(1'b1, 3'd2, 32'h104, 32'hDEADBEEF, r_rdata, r_wword, r_lat, r_err);
        check("sw_lit", r_wword, 32'hDEADBEEF);
        check("sw_lat", 32'(r_lat), 32'd2);
        run_txn(1'b1, 3'd1, 32'h101, 32'h0000BEEF, r_rdata, r_wword, r_lat, r_err);
        check("sh101_err", 32'(r_err), 32'd1);
        check("sh101_lat", 32'(r_lat), 32'd1);
        run_txn(1'b0, 3'd3, 32'h100, 32'd0, r_rdata, r_wword, r_lat, r_err);
        run_txn(1'b0, 3'd6, 32'h100, 32'd0, r_rdata, r_wword, r_lat, r_err);
        run_txn(1'b0, 3'd7, 32'h100, 32'd0, r_rdata, r_wword, r_lat, r_err);
        run_txn(1'b1, 3'd4, 32'h100, 32'd0, r_rdata, r_wword, r_lat, r_err);

        // Reset while in RD of an SB: access must be dropped.
        begin
            int bad_cycles;
            req_valid  = 1'b1;
            req_store  = 1'b1;
            req_funct3 = 3'd0;
            req_addr   = 32'h101;
            req_wdata  = 32'h000000EE;
            @(negedge clk);
            req_valid = 1'b0;
            rst       = 1'b1;
            bad_cycles = (mem_we || resp_valid) ? 1 : 0;
            @(negedge clk);
            check("abort_ready", 32'(req_ready), 32'd1);
            check("abort_mem_addr", mem_addr, 32'd0);
            rst = 1'b0;
            for (int i = 0; i < 5; i++) begin
                if (mem_we || resp_valid) bad_cycles++;
                @(negedge clk);
            end
            check("abort_no_activity", 32'(bad_cycles), 32'd0);
            check("abort_mem_intact", mem[64], ref_word(32'h100));
            $display("TXN %0d reset-abort SB addr=00000101", txn_no);
            txn_no++;
        end

        for (int t = 0; t < 250; t++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] addr;
            st   = 1'($urandom);
            addr = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 9) < 8) begin
                if (st) f3 = 3'($urandom_range(0, 2));
                else begin
                    f3 = 3'($urandom_range(0, 4));
                    if (f3 > 3'd2) f3 = f3 + 3'd1;
                end
            end else begin
                f3 = 3'($urandom);
            end
            run_txn(st, f3, addr, $urandom, r_rdata, r_wword, r_lat, r_err);
        end

        // Final sweep: DUT-written memory agrees with the reference.
        begin
            int diffs;
            diffs = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== ref_word(4*i)) diffs++;
            check("memory_image", 32'(diffs), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: CHECK_ALIGN, default 1; when 1, misaligned half/word accesses are rejected with err; when 0, the low address bits are ignored as if aligned.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  1  CPU access request.
REQ-005 req_ready  out  1  unit idle, request accepted when req_valid && req_ready.
REQ-006 req_store  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RV32I funct3: LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 resp_valid  out  1  one-cycle completion pulse.
REQ-011 resp_rdata  out  32  extended load result; 0 for stores and errors.
REQ-012 resp_err  out  1  misaligned or illegal funct3, qualified by resp_valid.
REQ-013 mem_we  out  1  data memory write enable, sampled on rising clk.
REQ-014 mem_addr  out  32  data memory byte address, always word-aligned ([1:0]=0).
REQ-015 mem_wdata  out  32  data memory write word, little-endian.
REQ-016 mem_rdata  in  32  data memory combinational read word at mem_addr.

Function
REQ-017 States SHALL be IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-018 On acceptance, funct3, store flag, address and wdata SHALL be captured; inputs are ignored until return to IDLE.
REQ-019 Error condition: load funct3 in {3,6,7}, store funct3 >=3, or (CHECK_ALIGN=1) half with addr[0]=1 or word with addr[1:0]!=0; IDLE->RESP with resp_err=1, no memory access.
REQ-020 Load: IDLE->RD->RESP; in RD mem_addr={addr[31:2],2'b00}, mem_we=0, extracted result registered at end of RD.
REQ-021 Load extraction: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
REQ-022 SW: IDLE->WR->RESP; in WR mem_we=1, mem_wdata=captured wdata.
REQ-023 SB/SH: IDLE->RD->WR->RESP; word captured in RD, WR writes the word with only the addressed byte/half lanes replaced by wdata[7:0]/wdata[15:0].
REQ-024 mem_we SHALL be 1 only in WR, exactly one cycle per store, never on error.
REQ-025 mem_addr SHALL hold the aligned captured address from acceptance until the next acceptance.
REQ-026 Latency acceptance-edge to resp_valid: error 1 cycle, load 2, SW 2, SB/SH 3.
REQ-027 resp_valid lasts exactly one cycle in RESP, then IDLE; no response backpressure.
REQ-028 resp_rdata/resp_err SHALL hold their values until the next response.

Reset
REQ-029 On rst sampled high: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-030 Reset mid-operation aborts the access: no resp_valid; if sampled in RD, no write occurs.

Structure
REQ-031 Shared package lsu_pkg: funct3 encodings, state enum.
REQ-032 Sub-module lsu_align (combinational): load extract/extend and store lane merge; FSM and registers in load_store_unit.

Verification
Memory preload: word 0x100 = 0x8899AABB.
REQ-033 LW 0x100 -> resp_valid 2 cycles after accept, rdata 0x8899AABB, err 0, mem_we never high.
REQ-034 LB 0x103 -> 0xFFFFFF88; LBU 0x103 -> 0x00000088; LH 0x102 -> 0xFFFF8899; LHU 0x100 -> 0x0000AABB.
REQ-035 SB 0x101, wdata 0x12345677 -> single mem_we cycle, mem_addr 0x100, mem_wdata 0x889977BB, resp 3 cycles after accept.
REQ-036 SH 0x102, wdata 0x0000CAFE -> write 0xCAFEAABB at 0x100; SW 0x104, wdata 0xDEADBEEF -> write 0xDEADBEEF, resp 2 cycles after accept.
REQ-037 LW 0x102 and SH 0x101 -> resp 1 cycle after accept, err 1, rdata 0, no mem_we; with CHECK_ALIGN=0, LW 0x102 returns 0x8899AABB.
REQ-038 SB 0x101 with rst high in RD cycle -> no mem_we ever, no resp_valid, req_ready 1 next cycle.
